// File: rtl/counter_bcd_pkg.sv
// Shared constants, state type and helpers for the BCD down-timer.
// Provides:
//   BCD_W        - width of one BCD digit
//   BCD_MAX      - largest legal digit value (wrap target on borrow)
//   BCD_MIN      - smallest digit value (borrow trigger)
//   DIGIT_CLAMP  - value substituted for any illegal preset digit (>9)
//   state_e      - timer FSM state (IDLE, RUN)
//   clamp_digit  - saturate one nibble to DIGIT_CLAMP
package counter_bcd_pkg;

  localparam int unsigned BCD_W       = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  BCD_MIN     = 4'd0;
  localparam logic [3:0]  DIGIT_CLAMP = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Saturate an arbitrary nibble into the legal BCD range.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DIGIT_CLAMP) ? DIGIT_CLAMP : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with synchronous load and borrow chain.
// Ports:
//   clk         - clock, rising edge
//   Reset       - synchronous active-high reset, clears digit to 0
//   load        - load load_digit this cycle (overrides dec_in)
//   load_digit  - value to load
//   dec_in      - borrow-in / decrement request from the lower digit
//   digit       - current digit value (registered)
//   borrow_out  - dec_in while digit is 0: this digit wraps and borrows
module bcd_digit_down
  import counter_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  // Digit register: reset > load > decrement with 0 -> 9 wrap.
  always_ff @(posedge clk) begin
    if (Reset) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= load_digit;
    end else if (dec_in) begin
      digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign borrow_out = dec_in && (digit == BCD_MIN);

endmodule

// File: rtl/counter_bcd_down_timer.sv
// Cascaded BCD down-timer with load, start and tick enable.
// Optional feature macro: COUNTER_BCD_DOWN_TIMER_AUTORELOAD_EN
//   defined   - on reaching zero the count reloads the last loaded preset
//               and the timer keeps running (Done still pulses)
//   undefined - on reaching zero the timer stops in IDLE holding 0
// Ports:
//   clk        - clock, rising edge
//   Reset      - synchronous active-high reset
//   Load       - load LoadValue (digits > 9 clamped to 9)
//   LoadValue  - BCD preset, digit 0 in bits [3:0]
//   Start      - request to start counting (IDLE only, count nonzero)
//   En         - tick enable; decrements only while running
//   Output     - current BCD count (registered)
//   Running    - high while in RUN
//   Done       - one-cycle pulse when a decrement reaches zero
//   Zero       - Output is all-zero (combinational from Output)
module counter_bcd_down_timer
  import counter_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
)
(
  input  logic                clk,
  input  logic                Reset,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadValue,
  input  logic                Start,
  input  logic                En,
  output logic [4*DIGITS-1:0] Output,
  output logic                Running,
  output logic                Done,
  output logic                Zero
);

  localparam int unsigned W = BCD_W * DIGITS;

  state_e         state;
  state_e         next_state_c;
  logic [W-1:0]   count;
  logic [W-1:0]   load_clamped_c;
  logic [W-1:0]   reload_val_c;
  logic [W-1:0]   dig_value_c;
  logic [DIGITS:0] borrow;
  logic           dec_c;
  logic           is_one_c;
  logic           terminal_c;
  logic           underflow_c;
  logic           reload_now_c;
  logic           dig_load_c;

  assign Output  = count;
  assign Zero    = (Output == '0);
  assign Running = (state == RUN);

  // Decrement request; Load takes priority over counting.
  assign dec_c      = (state == RUN) && En && !Load;
  assign is_one_c   = (count == W'(1));
  assign terminal_c = dec_c && is_one_c;
  // Borrow out of the top digit means a decrement from all-zero: never let
  // that wrap, force a reload of zero instead.
  assign underflow_c = borrow[DIGITS];
  assign borrow[0]   = dec_c;

`ifdef COUNTER_BCD_DOWN_TIMER_AUTORELOAD_EN
  logic [W-1:0] reload;

  // Last clamped preset, restored on each terminal decrement.
  always_ff @(posedge clk) begin
    if (Reset) begin
      reload <= '0;
    end else if (Load) begin
      reload <= load_clamped_c;
    end
  end

  // Empty reload register lets the count fall to 0 and stop.
  assign reload_now_c = terminal_c && (reload != '0);
  assign reload_val_c = reload;
`else
  assign reload_now_c = 1'b0;
  assign reload_val_c = '0;
`endif

  // Digits load on a user preset, an autoreload, or the underflow guard.
  assign dig_load_c  = Load || reload_now_c || underflow_c;
  assign dig_value_c = Load         ? load_clamped_c :
                       reload_now_c ? reload_val_c   : '0;

  // Digit chain: each digit decrements when all lower digits borrow.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign load_clamped_c[BCD_W*i +: BCD_W] = clamp_digit(LoadValue[BCD_W*i +: BCD_W]);

    bcd_digit_down u_digit (
      .clk        (clk),
      .Reset      (Reset),
      .load       (dig_load_c),
      .load_digit (dig_value_c[BCD_W*i +: BCD_W]),
      .dec_in     (borrow[i]),
      .digit      (count[BCD_W*i +: BCD_W]),
      .borrow_out (borrow[i+1])
    );
  end

  // Next-state decode: Load > Start > terminal decrement.
  always_comb begin
    next_state_c = state;
    if (Load) begin
      if ((state == RUN) && (load_clamped_c == '0)) begin
        next_state_c = IDLE;
      end
    end else if (state == IDLE) begin
      if (Start && !Zero) begin
        next_state_c = RUN;
      end
    end else if ((terminal_c && !reload_now_c) || underflow_c) begin
      next_state_c = IDLE;
    end
  end

  // State and Done pulse registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      Done  <= 1'b0;
    end else begin
      state <= next_state_c;
      Done  <= terminal_c;
    end
  end

endmodule

// File: tb/tb_counter_bcd_down_timer.sv
// Testbench for counter_bcd_down_timer: directed scenarios followed by
// randomized traffic, all checked against a decimal-integer reference model.
module tb_counter_bcd_down_timer;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         Reset;
  logic         Load;
  logic [W-1:0] LoadValue;
  logic         Start;
  logic         En;
  logic [W-1:0] Output;
  logic         Running;
  logic         Done;
  logic         Zero;

  int tests  = 0;
  int failed = 0;

  // Reference model state: count as a plain integer.
  int mval    = 0;
  int mreload = 0;
  bit mrun    = 1'b0;
  bit mdone   = 1'b0;

  always #5 clk = ~clk;

  counter_bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Start     (Start),
    .En        (En),
    .Output    (Output),
    .Running   (Running),
    .Done      (Done),
    .Zero      (Zero)
  );

  // Interpret a preset as a decimal number, saturating illegal digits to 9.
  function automatic int preset_to_int(input logic [W-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit l, input logic [W-1:0] lv,
                            input bit s, input bit e);
    mdone = 1'b0;
    if (r) begin
      mval = 0; mreload = 0; mrun = 1'b0;
    end else if (l) begin
      mval    = preset_to_int(lv);
      mreload = mval;
      if (mrun && mval == 0) mrun = 1'b0;
    end else if (!mrun) begin
      if (s && mval != 0) mrun = 1'b1;
    end else if (e && mval != 0) begin
      mval = mval - 1;
      if (mval == 0) begin
        mdone = 1'b1;
`ifdef COUNTER_BCD_DOWN_TIMER_AUTORELOAD_EN
        if (mreload != 0) mval = mreload;
        else mrun = 1'b0;
`else
        mrun = 1'b0;
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input bit r, input bit l, input logic [W-1:0] lv,
                      input bit s, input bit e, input string tag);
    Reset = r; Load = l; LoadValue = lv; Start = s; En = e;
    @(posedge clk);
    #1;
    model_step(r, l, lv, s, e);
    chk({tag, ".out"},  32'(Output),  32'(int_to_bcd(mval)));
    chk({tag, ".run"},  32'(Running), 32'(mrun));
    chk({tag, ".done"}, 32'(Done),    32'(mdone));
    chk({tag, ".zero"}, 32'(Zero),    32'(mval == 0));
  endtask

  initial begin
    logic [W-1:0] lv;
    Reset = 1'b0; Load = 1'b0; LoadValue = '0; Start = 1'b0; En = 1'b0;

    // Reset state
    step(1, 0, '0, 1, 1, "rst");
    chk("rst.zero_const", 32'(Zero), 32'd1);
    chk("rst.out_const", 32'(Output), 32'h00);

`ifndef COUNTER_BCD_DOWN_TIMER_AUTORELOAD_EN
    // Count 03 down to 00
    step(0, 1, 8'h03, 0, 0, "l03");
    step(0, 0, '0, 1, 1, "start03");
    chk("start03.out_const", 32'(Output), 32'h03);
    step(0, 0, '0, 0, 1, "dec02");
    step(0, 0, '0, 0, 1, "dec01");
    chk("dec01.done_const", 32'(Done), 32'd0);
    step(0, 0, '0, 0, 1, "dec00");
    chk("dec00.out_const",  32'(Output),  32'h00);
    chk("dec00.done_const", 32'(Done),    32'd1);
    chk("dec00.run_const",  32'(Running), 32'd0);
    step(0, 0, '0, 0, 1, "hold00");
    chk("hold00.done_const", 32'(Done), 32'd0);

    // Borrow 10 -> 09
    step(0, 1, 8'h10, 0, 0, "l10");
    step(0, 0, '0, 1, 1, "start10");
    step(0, 0, '0, 0, 1, "dec09");
    chk("dec09.out_const",  32'(Output), 32'h09);
    chk("dec09.zero_const", 32'(Zero),   32'd0);

    // Clamp and start-at-zero
    step(1, 0, '0, 0, 0, "rst2");
    step(0, 1, 8'hA5, 0, 0, "lA5");
    chk("lA5.out_const", 32'(Output), 32'h95);
    step(0, 1, 8'h00, 0, 0, "l00");
    step(0, 0, '0, 1, 1, "start00");
    chk("start00.run_const", 32'(Running), 32'd0);

    // Reset aborts a count
    step(0, 1, 8'h05, 0, 0, "l05");
    step(0, 0, '0, 1, 0, "start05");
    step(0, 0, '0, 0, 1, "dec04");
    step(0, 0, '0, 0, 1, "dec03");
    step(1, 0, '0, 0, 1, "abort");
    chk("abort.done_const", 32'(Done), 32'd0);

    // En gating, then Load+Start+En together while running
    step(0, 1, 8'h02, 0, 0, "l02");
    step(0, 0, '0, 1, 0, "start02");
    step(0, 0, '0, 0, 1, "en1");
    step(0, 0, '0, 0, 0, "en0");
    chk("en0.out_const", 32'(Output), 32'h01);
    step(0, 0, '0, 0, 1, "en1b");
    step(0, 1, 8'h05, 0, 0, "l05b");
    step(0, 0, '0, 1, 0, "start05b");
    step(0, 1, 8'h07, 1, 1, "l07");
    chk("l07.out_const", 32'(Output),  32'h07);
    chk("l07.run_const", 32'(Running), 32'd1);
`else
    // Autoreload: 02 -> 01,02,01,02,01,02
    step(0, 1, 8'h02, 0, 0, "l02");
    step(0, 0, '0, 1, 0, "start02");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, 0, 1, "ar");
      chk("ar.out_const",  32'(Output),  (i % 2 == 0) ? 32'h01 : 32'h02);
      chk("ar.done_const", 32'(Done),    (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("ar.run_const",  32'(Running), 32'd1);
    end
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      lv = W'($urandom);
      if ($urandom_range(0, 3) == 0) lv = W'($urandom_range(0, 3));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, lv,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
